vram_write_arbiter: RTL and testbench
=====================================

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter BORDER_EN, default 1, enabling the cell border colour.
REQ-002 SHALL have parameter BORDER_COLOR, default 3'b111, giving the RGB value of cell edge pixels.
REQ-003 Clock  in  1  system clock; all state on rising edge.
REQ-004 Reset  in  1  one clock; reset is asynchronous and active-high.
REQ-005 iCpuWe  in  1  CPU pixel write strobe, one cycle per pixel.
REQ-006 iCpuX / iCpuY  in  8 / 8  CPU pixel column / row.
REQ-007 iCpuColor  in  3  CPU pixel RGB.
REQ-008 iFillStart  in  1  request to paint one board cell.
REQ-009 iCellIndex  in  4  cell number 0-15; column = [1:0], row = [3:2].
REQ-010 iCellColor  in  3  cell interior RGB.
REQ-011 iFillAbort  in  1  cancel active and pending fill.
REQ-012 oWe  out  1  video RAM write enable, registered.
REQ-013 oWrAddr  out  16  {column[7:0], row[7:0]}, registered.
REQ-014 oWrData  out  3  pixel RGB, registered.
REQ-015 oFillBusy  out  1  high when FSM is not IDLE.
REQ-016 oPendFull  out  1  high when the pending-fill slot holds a request.
REQ-017 oFillDone  out  1  one-cycle pulse when a cell fill completes.

Function
REQ-018 SHALL own the single write port of the 256x256x3 video RAM; the block is its only writer.
REQ-019 SHALL grant the write port each cycle with fixed priority: CPU request, then fill engine, else no write.
REQ-020 SHALL load oWe/oWrAddr/oWrData at the edge ending the grant cycle; latency is exactly 1 cycle; oWe=0 when nothing is granted.
REQ-021 A CPU write SHALL never be dropped or delayed; a fill pixel losing arbitration SHALL stall with its counters held.
REQ-022 FSM states SHALL be IDLE, FILL and DONE.
REQ-023 IDLE -> FILL on iFillStart; cell index and colour latched; counters xc=yc=0.
REQ-024 In FILL, each granted pixel SHALL be written at column {col,xc}, row {row,yc}; xc is 6 bits and increments per grant; yc increments when xc wraps 63->0.
REQ-025 A pixel with xc or yc equal to 0 or 63 SHALL use BORDER_COLOR when BORDER_EN=1; all other pixels use the latched cell colour.
REQ-026 FILL -> DONE after the grant with xc=yc=63; exactly 4096 writes per cell.
REQ-027 oFillDone SHALL be high only during the DONE cycle, coincident with the last pixel on oWe.
REQ-028 DONE -> FILL with the pending request loaded and pending cleared if oPendFull; otherwise DONE -> IDLE.
REQ-029 iFillStart in FILL or DONE with the pending slot empty SHALL capture the request into the pending slot.
REQ-030 iFillStart with the pending slot full SHALL be dropped; the pending contents are unchanged.
REQ-031 iFillStart in the DONE cycle while the slot is being consumed SHALL refill the slot at the same edge.
REQ-032 iFillAbort SHALL force IDLE at the next edge and clear the pending slot, with no oFillDone pulse.
REQ-033 A pixel already in the output register at abort SHALL still appear on oWe.
REQ-034 iFillAbort has priority over iFillStart in the same cycle; the start is dropped.
REQ-035 A CPU write is unaffected by abort or start in the same cycle.
REQ-036 Coordinates SHALL be unsigned 8 bit; no wrap beyond the cell, because cell origin = index*64 and 4*64 = 256.

Reset
REQ-037 Reset SHALL asynchronously set oWe=0, oWrAddr=0, oWrData=0, oFillDone=0 and oPendFull=0.
REQ-038 Reset SHALL set FSM=IDLE (oFillBusy=0), xc=yc=0 and clear all latched requests.
REQ-039 Reset asserted mid-fill SHALL abandon the fill with no further writes; operation resumes from IDLE after release.

Verification
REQ-040 CPU write (X=5, Y=9, colour 3'b010) in cycle k -> oWe=1, oWrAddr=16'h0509, oWrData=3'b010 in cycle k+1 only.
REQ-041 Fill cell 9 (colour 3'b100), no CPU traffic -> 4096 writes; first at 16'h4080 with BORDER_COLOR; pixel (0x45,0x85) = 3'b100; last at 16'h7FBF; oFillDone in the last-write cycle.
REQ-042 CPU strobe every 4th cycle during a fill -> every CPU write appears 1 cycle later, no fill pixel lost or duplicated, total 4096 fill writes.
REQ-043 Start cell 0 then cell 15 mid-fill, then cell 3 -> oPendFull=1, cell 3 dropped; cell 15 begins the cycle after oFillDone for cell 0 with no idle gap.
REQ-044 Abort at fill pixel 100 with pending full -> IDLE and oPendFull=0 next edge, no oFillDone pulse, at most one further oWe.
REQ-045 Reset asserted mid-fill for 1 cycle -> all outputs 0 immediately, no further writes; a new fill then completes normally.

Source files
------------

// File: rtl/vram_wr_if.sv
// Bundles the CPU pixel port, the cell-fill request port and the video RAM write port.
// The slave modport is the arbiter's view. The master modport is the requester's view.
interface vram_wr_if;
  logic        cpu_we_i;
  logic [7:0]  cpu_x_i;
  logic [7:0]  cpu_y_i;
  logic [2:0]  cpu_color_i;
  logic        fill_start_i;
  logic [3:0]  cell_index_i;
  logic [2:0]  cell_color_i;
  logic        fill_abort_i;
  logic        we_o;
  logic [15:0] wr_addr_o;
  logic [2:0]  wr_data_o;
  logic        fill_busy_o;
  logic        pend_full_o;
  logic        fill_done_o;

  modport slave (
    input  cpu_we_i, cpu_x_i, cpu_y_i, cpu_color_i,
    input  fill_start_i, cell_index_i, cell_color_i, fill_abort_i,
    output we_o, wr_addr_o, wr_data_o, fill_busy_o, pend_full_o, fill_done_o
  );

  modport master (
    output cpu_we_i, cpu_x_i, cpu_y_i, cpu_color_i,
    output fill_start_i, cell_index_i, cell_color_i, fill_abort_i,
    input  we_o, wr_addr_o, wr_data_o, fill_busy_o, pend_full_o, fill_done_o
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// This block is the only writer of the 256x256x3 video RAM. CPU pixel writes have fixed priority.
// When the CPU is idle, a cell-fill engine paints 64x64 board cells and holds one queued request.
module vram_write_arbiter #(
  parameter bit         BORDER_EN    = 1'b1,
  parameter logic [2:0] BORDER_COLOR = 3'b111
) (
  input  logic     clk,
  input  logic     rst,
  vram_wr_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  xc_q, xc_d;
  logic [5:0]  yc_q, yc_d;
  logic [3:0]  cur_idx_q, cur_idx_d;
  logic [2:0]  cur_col_q, cur_col_d;
  logic        pend_q, pend_d;
  logic [3:0]  pend_idx_q, pend_idx_d;
  logic [2:0]  pend_col_q, pend_col_d;
  logic        we_q;
  logic [15:0] addr_q;
  logic [2:0]  data_q;

  logic        fill_grant;
  logic        last_px;
  logic        border_px;
  logic        start_ok;
  logic        consume;
  logic        capture;
  logic [15:0] fill_addr;
  logic [2:0]  fill_data;

  // A fill pixel is not granted in an abort cycle. Only a pixel already in the output register can still appear.
  assign fill_grant = (state_q == S_FILL) && !bus.fill_abort_i && !bus.cpu_we_i;
  assign last_px    = (xc_q == 6'd63) && (yc_q == 6'd63);
  assign border_px  = (xc_q == 6'd0) || (xc_q == 6'd63) || (yc_q == 6'd0) || (yc_q == 6'd63);
  assign fill_addr  = {cur_idx_q[1:0], xc_q, cur_idx_q[3:2], yc_q};
  assign fill_data  = (BORDER_EN && border_px) ? BORDER_COLOR : cur_col_q;

  assign start_ok = bus.fill_start_i && !bus.fill_abort_i;
  assign consume  = pend_q && ((state_q == S_DONE) || (state_q == S_IDLE));
  // A full slot accepts a new request only at the edge where the slot is emptied into the engine.
  assign capture  = start_ok && (pend_q ? consume : (state_q != S_IDLE));

  always_comb begin
    // NOTE: every next-state variable gets a hold default first, so no path infers a latch.
    state_d    = state_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    cur_idx_d  = cur_idx_q;
    cur_col_d  = cur_col_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    pend_col_d = pend_col_q;

    if (bus.fill_abort_i) begin
      state_d = S_IDLE;
      xc_d    = 6'd0;
      yc_d    = 6'd0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (consume) begin
            state_d   = S_FILL;
            cur_idx_d = pend_idx_q;
            cur_col_d = pend_col_q;
            pend_d    = 1'b0;
          end else if (start_ok) begin
            state_d   = S_FILL;
            cur_idx_d = bus.cell_index_i;
            cur_col_d = bus.cell_color_i;
          end
          xc_d = 6'd0;
          yc_d = 6'd0;
        end
        S_FILL: begin
          if (fill_grant) begin
            xc_d = xc_q + 6'd1;
            if (xc_q == 6'd63) yc_d = yc_q + 6'd1;
            if (last_px)       state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (consume) begin
            state_d   = S_FILL;
            cur_idx_d = pend_idx_q;
            cur_col_d = pend_col_q;
            pend_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
          xc_d = 6'd0;
          yc_d = 6'd0;
        end
        default: state_d = S_IDLE;
      endcase

      if (capture) begin
        pend_d     = 1'b1;
        pend_idx_d = bus.cell_index_i;
        pend_col_d = bus.cell_color_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      xc_q       <= 6'd0;
      yc_q       <= 6'd0;
      cur_idx_q  <= 4'd0;
      cur_col_q  <= 3'd0;
      pend_q     <= 1'b0;
      pend_idx_q <= 4'd0;
      pend_col_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      cur_idx_q  <= cur_idx_d;
      cur_col_q  <= cur_col_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_col_q <= pend_col_d;
    end
  end

  // The write port register holds its address and data when idle. Only we_q marks a valid write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= 16'd0;
      data_q <= 3'd0;
    end else begin
      we_q <= bus.cpu_we_i || fill_grant;
      if (bus.cpu_we_i) begin
        addr_q <= {bus.cpu_x_i, bus.cpu_y_i};
        data_q <= bus.cpu_color_i;
      end else if (fill_grant) begin
        addr_q <= fill_addr;
        data_q <= fill_data;
      end
    end
  end

  assign bus.we_o        = we_q;
  assign bus.wr_addr_o   = addr_q;
  assign bus.wr_data_o   = data_q;
  assign bus.fill_busy_o = (state_q != S_IDLE);
  assign bus.pend_full_o = pend_q;
  assign bus.fill_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter. It uses a pixel-order model for the fill engine
// and hand-computed addresses at the cell corners and at the abort point.
module tb_vram_write_arbiter;

  logic clk;
  logic rst;
  vram_wr_if bus ();

  vram_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] first_addr, last_addr;
  logic [2:0]  first_data, probe_data;
  int          fill_writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill pixel n lands at column {col, n[5:0]} and row {row, n[11:6]}, in raster order within the cell.
  task automatic fill_watch(input logic [3:0] idx, input logic [2:0] col,
                            input int cpu_period, input int start_n);
    int          n = start_n;
    int          bad = 0;
    bit          done_seen = 1'b0;
    bit          cpu_cyc;
    logic [11:0] nn;
    logic [15:0] ea;
    logic [2:0]  ed;
    fill_writes = 0;
    for (int cyc = 0; cyc < 12000 && !done_seen; cyc++) begin
      cpu_cyc = (cpu_period > 0) && (cyc % cpu_period == 0);
      if (cpu_cyc) begin
        bus.cpu_we_i    = 1'b1;
        bus.cpu_x_i     = 8'(cyc);
        bus.cpu_y_i     = 8'(cyc * 3 + 1);
        bus.cpu_color_i = 3'(cyc + 2);
        ea = {8'(cyc), 8'(cyc * 3 + 1)};
        ed = 3'(cyc + 2);
      end
      tick();
      bus.cpu_we_i = 1'b0;
      if (cpu_cyc) begin
        if (!(bus.we_o === 1'b1 && bus.wr_addr_o === ea && bus.wr_data_o === ed
              && bus.fill_done_o === 1'b0)) bad++;
      end else begin
        nn = 12'(n);
        ea = {idx[1:0], nn[5:0], idx[3:2], nn[11:6]};
        ed = (nn[5:0] == 6'd0 || nn[5:0] == 6'd63 || nn[11:6] == 6'd0 || nn[11:6] == 6'd63)
             ? 3'b111 : col;
        if (!(bus.we_o === 1'b1 && bus.wr_addr_o === ea && bus.wr_data_o === ed)) bad++;
        if (bus.fill_done_o !== (n == 4095)) bad++;
        if (n == 0)    begin first_addr = bus.wr_addr_o; first_data = bus.wr_data_o; end
        if (n == 325)  probe_data = bus.wr_data_o;
        if (n == 4095) begin last_addr = bus.wr_addr_o; done_seen = 1'b1; end
        n++;
        fill_writes++;
      end
    end
    check("fill_pixel_stream", bad, 0);
    check("fill_done_reached", done_seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    int dcount;
    rst = 1'b1;
    bus.cpu_we_i = 1'b0; bus.cpu_x_i = 8'd0; bus.cpu_y_i = 8'd0; bus.cpu_color_i = 3'd0;
    bus.fill_start_i = 1'b0; bus.cell_index_i = 4'd0; bus.cell_color_i = 3'd0;
    bus.fill_abort_i = 1'b0;
    tick();
    check("rst_we", bus.we_o, 0);
    check("rst_addr", bus.wr_addr_o, 0);
    check("rst_data", bus.wr_data_o, 0);
    check("rst_busy", bus.fill_busy_o, 0);
    check("rst_pend", bus.pend_full_o, 0);
    check("rst_done", bus.fill_done_o, 0);
    rst = 1'b0;
    tick();

    // Single CPU write. It appears one cycle later and only for one cycle.
    bus.cpu_we_i = 1'b1; bus.cpu_x_i = 8'd5; bus.cpu_y_i = 8'd9; bus.cpu_color_i = 3'b010;
    tick();
    bus.cpu_we_i = 1'b0;
    check("cpu_we", bus.we_o, 1);
    check("cpu_addr", bus.wr_addr_o, 16'h0509);
    check("cpu_data", bus.wr_data_o, 3'b010);
    tick();
    check("cpu_we_once", bus.we_o, 0);

    // Cell 9 fill with no CPU traffic.
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd9; bus.cell_color_i = 3'b100;
    tick();
    bus.fill_start_i = 1'b0;
    check("c9_busy", bus.fill_busy_o, 1);
    fill_watch(4'd9, 3'b100, 0, 0);
    check("c9_writes", fill_writes, 4096);
    check("c9_first_addr", first_addr, 16'h4080);
    check("c9_first_data", first_data, 3'b111);
    check("c9_probe_data", probe_data, 3'b100);
    check("c9_last_addr", last_addr, 16'h7FBF);
    tick();
    check("c9_idle", bus.fill_busy_o, 0);
    check("c9_done_pulse", bus.fill_done_o, 0);
    check("c9_we_off", bus.we_o, 0);

    // Cell 6 fill with a CPU strobe on every 4th cycle.
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd6; bus.cell_color_i = 3'b011;
    tick();
    bus.fill_start_i = 1'b0;
    fill_watch(4'd6, 3'b011, 4, 0);
    check("c6_writes", fill_writes, 4096);
    tick();
    check("c6_idle", bus.fill_busy_o, 0);

    // Cell 0, then cell 15 queued, then cell 3 dropped. Cell 15 follows cell 0 directly.
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd0; bus.cell_color_i = 3'b001;
    tick();
    bus.cell_index_i = 4'd15; bus.cell_color_i = 3'b110;
    tick();
    check("q_pend_set", bus.pend_full_o, 1);
    check("q_c0_px0", bus.wr_addr_o, 16'h0000);
    bus.cell_index_i = 4'd3; bus.cell_color_i = 3'b010;
    tick();
    bus.fill_start_i = 1'b0;
    check("q_pend_kept", bus.pend_full_o, 1);
    check("q_c0_px1", bus.wr_addr_o, 16'h0100);
    fill_watch(4'd0, 3'b001, 0, 2);
    check("q_done_pend", bus.pend_full_o, 1);
    tick();
    check("q_c15_busy", bus.fill_busy_o, 1);
    check("q_c15_pend_clr", bus.pend_full_o, 0);
    fill_watch(4'd15, 3'b110, 0, 0);
    check("q_c15_first", first_addr, 16'hC0C0);
    check("q_c15_last", last_addr, 16'hFFFF);
    tick();
    check("q_c3_dropped", bus.fill_busy_o, 0);

    // Abort at pixel 100 with the slot full. The abort cycle also carries a start and a CPU write.
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd5; bus.cell_color_i = 3'b010;
    tick();
    bus.cell_index_i = 4'd10; bus.cell_color_i = 3'b110;
    tick();
    bus.fill_start_i = 1'b0;
    for (int k = 1; k < 100; k++) tick();
    check("ab_px99", bus.wr_addr_o, 16'h6341);
    check("ab_pend_full", bus.pend_full_o, 1);
    bus.fill_abort_i = 1'b1; bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd7;
    bus.cpu_we_i = 1'b1; bus.cpu_x_i = 8'hAA; bus.cpu_y_i = 8'h55; bus.cpu_color_i = 3'b101;
    tick();
    bus.fill_abort_i = 1'b0; bus.fill_start_i = 1'b0; bus.cpu_we_i = 1'b0;
    check("ab_busy", bus.fill_busy_o, 0);
    check("ab_pend", bus.pend_full_o, 0);
    check("ab_done", bus.fill_done_o, 0);
    check("ab_cpu_we", bus.we_o, 1);
    check("ab_cpu_addr", bus.wr_addr_o, 16'hAA55);
    check("ab_cpu_data", bus.wr_data_o, 3'b101);
    wcount = 0; dcount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      wcount += int'(bus.we_o);
      dcount += int'(bus.fill_done_o) + int'(bus.fill_busy_o);
    end
    check("ab_no_writes", wcount, 0);
    check("ab_no_restart", dcount, 0);

    // Reset asserted mid-fill clears the outputs at once. A later fill completes normally.
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd12; bus.cell_color_i = 3'b101;
    tick();
    bus.cell_index_i = 4'd1;
    tick();
    bus.fill_start_i = 1'b0;
    for (int k = 0; k < 48; k++) tick();
    check("rs_pre_pend", bus.pend_full_o, 1);
    #2 rst = 1'b1;
    #1;
    check("rs_we", bus.we_o, 0);
    check("rs_addr", bus.wr_addr_o, 0);
    check("rs_data", bus.wr_data_o, 0);
    check("rs_busy", bus.fill_busy_o, 0);
    check("rs_pend", bus.pend_full_o, 0);
    check("rs_done", bus.fill_done_o, 0);
    tick();
    rst = 1'b0;
    wcount = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      wcount += int'(bus.we_o) + int'(bus.fill_busy_o);
    end
    check("rs_quiet", wcount, 0);
    bus.fill_start_i = 1'b1; bus.cell_index_i = 4'd3; bus.cell_color_i = 3'b010;
    tick();
    bus.fill_start_i = 1'b0;
    fill_watch(4'd3, 3'b010, 0, 0);
    check("rs_c3_writes", fill_writes, 4096);
    check("rs_c3_last", last_addr, 16'hFF3F);
    tick();
    check("rs_c3_idle", bus.fill_busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
